parity_engine: RTL
==================

Name: parity_engine

Overview:
- Parametrised parity generator and checker for the UART datapath.
- Replaces the single-function even/odd parity calculator with:
  - a generate path for TX;
  - a check path for RX;
  - four parity types plus a disable;
  - sticky error status and saturating error and frame counters for the register file.
- Sits between the UART framers and the ALU/reg-file control, all in one clock domain.

Parameters:
- WIDTH, 8, data word width in bits (1..16).
- CNT_WIDTH, 8, width of the error and frame counters (2..16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- par_en_in  input  1  1 = parity enabled; 0 = parity disabled.
- par_type_in  input  2  parity type: 00 even, 01 odd, 10 mark (bit=1), 11 space (bit=0).
- gen_valid_in  input  1  generate request; qualifies gen_data_in.
- gen_data_in  input  WIDTH  TX data word.
- gen_valid_out  output  1  one-cycle pulse; par_bit_out updated this cycle.
- par_bit_out  output  1  generated parity bit; held between requests.
- chk_valid_in  input  1  check request; qualifies chk_data_in and chk_par_in.
- chk_data_in  input  WIDTH  RX data word.
- chk_par_in  input  1  received parity bit.
- chk_valid_out  output  1  one-cycle pulse; par_err_out valid this cycle.
- par_err_out  output  1  parity mismatch for the checked word; valid only with chk_valid_out.
- err_sticky_out  output  1  set on any mismatch; held until cleared.
- err_count_out  output  CNT_WIDTH  saturating count of mismatches.
- frame_count_out  output  CNT_WIDTH  saturating count of checked words.
- clear_in  input  1  synchronous clear of err_sticky_out, err_count_out and frame_count_out.

Behaviour:
- Reset:
  - reset=1 at a rising edge forces all outputs to 0.
  - Reset has priority over every other input, including in-flight requests; a request presented during reset is dropped.
- Expected parity bit P(d):
  - even: P = XOR-reduce(d), so data plus parity has an even number of 1s.
  - odd: P = ~XOR-reduce(d).
  - mark: P = 1.
  - space: P = 0.
- Configuration: par_en_in and par_type_in are sampled in the same cycle as each valid input. No shadowing is applied; a change takes effect on the next request.
- Generate path, latency 1:
  - gen_valid_in=1 at edge N gives gen_valid_out=1 in cycle N+1.
  - If par_en_in=1, par_bit_out=P(gen_data_in) in cycle N+1.
  - If par_en_in=0, par_bit_out holds its previous value and gen_valid_out still pulses.
  - Back-to-back requests are accepted every cycle; there is no backpressure.
  - par_bit_out holds whenever there is no request.
- Check path, latency 1:
  - chk_valid_in=1 at edge N gives chk_valid_out=1 in cycle N+1.
  - par_err_out=(chk_par_in != P(chk_data_in)) when par_en_in=1; par_err_out=0 when par_en_in=0.
  - par_err_out is 0 whenever chk_valid_out=0.
- Counters and sticky flag:
  - These update on the same edge that registers chk_valid_out.
  - frame_count_out increments per accepted check, including when par_en_in=0.
  - err_count_out increments per mismatch.
  - Both counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - err_sticky_out sets on a mismatch.
- clear_in:
  - clear_in=1 alone zeroes the sticky flag and both counters on the next edge.
  - clear_in together with an accepted check in the same cycle: the check is not lost. The counters load the post-clear value: frame=1, err=1 if mismatch else 0, sticky=1 if mismatch else 0.
- Generate and check paths are independent and may both be active in the same cycle.

Test Plan:
- Reset, then WIDTH=8, par_en=1, type even. Gen 0xA5, then 0x07 on consecutive cycles -> par_bit_out=0 then 1, with gen_valid_out high for 2 cycles at 1-cycle latency. Same sequence with type odd -> 1 then 0.
- Mark, then space, with gen 0x00 -> par_bit_out=1, then 0. Set par_en=0 and gen 0x07 -> gen_valid_out pulses and par_bit_out holds 0.
- Even, chk 0x07 with chk_par_in=0 -> par_err_out=1, err_sticky=1, err_count=1, frame_count=1. Then chk 0x07 with chk_par_in=1 -> par_err_out=0, err_count=1, frame_count=2.
- CNT_WIDTH=2: 5 mismatching checks -> err_count_out=3 and frame_count_out=3, saturated with no wrap. Then clear_in alone -> all three zero next cycle.
- clear_in together with a mismatching check -> next cycle err_count=1, frame_count=1, sticky=1. Repeat with a matching check -> err_count=0, frame_count=1, sticky=0.
- Assert reset in the same cycle as gen_valid_in and chk_valid_in -> next cycle all outputs 0 and no valid pulses. Simultaneous gen and chk requests -> both valid outputs pulse in the same cycle.

Source files
------------

// File: rtl/parity_engine.sv
// -----------------------------------------------------------------------------
// parity_engine
//   Parity generator (TX) and checker (RX) for the UART datapath, with sticky
//   error status and saturating error/frame counters for the register file.
//
// Parameters:
//   WIDTH      data word width (1..16)
//   CNT_WIDTH  width of the error and frame counters (2..16)
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   par_en_in         1 = parity enabled
//   par_type_in       00 even, 01 odd, 10 mark, 11 space
//   gen_valid_in      generate request, qualifies gen_data_in
//   gen_data_in       TX data word
//   gen_valid_out     one-cycle pulse, par_bit_out updated this cycle
//   par_bit_out       generated parity bit, held between requests
//   chk_valid_in      check request, qualifies chk_data_in / chk_par_in
//   chk_data_in       RX data word
//   chk_par_in        received parity bit
//   chk_valid_out     one-cycle pulse, par_err_out valid this cycle
//   par_err_out       parity mismatch of the checked word (0 when no pulse)
//   err_sticky_out    set on any mismatch, held until clear_in
//   err_count_out     saturating mismatch count
//   frame_count_out   saturating checked-word count
//   clear_in          synchronous clear of sticky flag and both counters
//
// Handshake: both paths are valid-only (no ready). A request is accepted on
// every rising edge where its valid input is high and reset is low; the
// matching *_valid_out pulses for exactly one cycle one clock later. There is
// no backpressure, so back-to-back requests are accepted every cycle.
// -----------------------------------------------------------------------------
module parity_engine #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 par_en_in,
  input  logic [1:0]           par_type_in,
  input  logic                 gen_valid_in,
  input  logic [WIDTH-1:0]     gen_data_in,
  output logic                 gen_valid_out,
  output logic                 par_bit_out,
  input  logic                 chk_valid_in,
  input  logic [WIDTH-1:0]     chk_data_in,
  input  logic                 chk_par_in,
  output logic                 chk_valid_out,
  output logic                 par_err_out,
  output logic                 err_sticky_out,
  output logic [CNT_WIDTH-1:0] err_count_out,
  output logic [CNT_WIDTH-1:0] frame_count_out,
  input  logic                 clear_in
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Expected parity bit for a word under the selected parity type.
  function automatic logic calc_par(input logic [WIDTH-1:0] d,
                                    input logic [1:0]       t);
    logic p;
    case (t)
      2'b00:   p = ^d;
      2'b01:   p = ~(^d);
      2'b10:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  logic                 gen_par;
  logic                 chk_mismatch;
  logic [CNT_WIDTH-1:0] frame_base;
  logic [CNT_WIDTH-1:0] err_base;
  logic                 sticky_base;
  logic [CNT_WIDTH-1:0] frame_next;
  logic [CNT_WIDTH-1:0] err_next;
  logic                 sticky_next;

  always_comb begin
    gen_par      = calc_par(gen_data_in, par_type_in);
    chk_mismatch = par_en_in && (chk_par_in != calc_par(chk_data_in, par_type_in));

    // clear_in zeroes the status first; a check in the same cycle then
    // accumulates on top of the cleared value so it is never lost.
    frame_base  = clear_in ? '0   : frame_count_out;
    err_base    = clear_in ? '0   : err_count_out;
    sticky_base = clear_in ? 1'b0 : err_sticky_out;

    frame_next = frame_base;
    if (chk_valid_in && (frame_base != CNT_MAX)) begin
      frame_next = frame_base + CNT_ONE;
    end

    err_next = err_base;
    if (chk_valid_in && chk_mismatch && (err_base != CNT_MAX)) begin
      err_next = err_base + CNT_ONE;
    end

    sticky_next = sticky_base | (chk_valid_in & chk_mismatch);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_valid_out   <= 1'b0;
      par_bit_out     <= 1'b0;
      chk_valid_out   <= 1'b0;
      par_err_out     <= 1'b0;
      err_sticky_out  <= 1'b0;
      err_count_out   <= '0;
      frame_count_out <= '0;
    end else begin
      gen_valid_out <= gen_valid_in;
      // Disabled parity still acknowledges the request but keeps the old bit.
      if (gen_valid_in && par_en_in) begin
        par_bit_out <= gen_par;
      end

      chk_valid_out   <= chk_valid_in;
      par_err_out     <= chk_valid_in & chk_mismatch;
      err_sticky_out  <= sticky_next;
      err_count_out   <= err_next;
      frame_count_out <= frame_next;
    end
  end

endmodule
